// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port flash read arbiter.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick between requesters A and B.
module rr_arb2
    import flash_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic gnt_valid,
    output logic gnt_b
);

    // On a tie, B wins only if A was the last port served.
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_b     = req_b & (~req_a | (last_b == PORT_A));
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one SPI flash read engine between a boot copier (A) and an XIP fetch path (B).
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter bit RESET_PRIO_A = 1'b1
) (
    input  logic              clk,
    input  logic              n_reset,

    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] a_count,
    output logic              a_strobe,
    output logic [31:0]       a_data,
    output logic              a_ack,
    output logic              a_err,

    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [ADDR_W-1:0] b_count,
    output logic              b_strobe,
    output logic [31:0]       b_data,
    output logic              b_ack,
    output logic              b_err,

    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_address,
    output logic [ADDR_W-1:0] rd_word_count,
    input  logic              rd_strobe,
    input  logic [31:0]       rd_data,
    input  logic              rd_done,

    output logic              busy,
    output logic              grant_b
);

    state_t            state;
    state_t            state_nxt;
    logic              last_b;
    logic              gnt_valid;
    logic              gnt_pick_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] sel_count;
    logic [ADDR_W-1:0] word_cnt;
    logic              xfer_err;
    logic              ack_cycle;
    logic              fwd;

    rr_arb2 u_rr_arb2 (
        .req_a     (a_req),
        .req_b     (b_req),
        .last_b    (last_b),
        .gnt_valid (gnt_valid),
        .gnt_b     (gnt_pick_b)
    );

    always_comb begin
        sel_addr  = gnt_pick_b ? b_addr  : a_addr;
        sel_count = gnt_pick_b ? b_count : a_count;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = (sel_count == '0) ? ACK : ISSUE;
            ISSUE:   if (rd_done)   state_nxt = RELEASE;
            RELEASE: if (!rd_done)  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    // Strobes are forwarded through RELEASE too, so a word racing rd_done is never lost.
    assign fwd = rd_strobe && (state == ISSUE || state == RELEASE);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_start      <= 1'b0;
            rd_address    <= '0;
            rd_word_count <= '0;
            grant_b       <= PORT_A;
            last_b        <= RESET_PRIO_A;
            word_cnt      <= '0;
            a_strobe      <= 1'b0;
            a_data        <= '0;
            b_strobe      <= 1'b0;
            b_data        <= '0;
        end else begin
            a_strobe <= 1'b0;
            b_strobe <= 1'b0;

            if (state == IDLE && gnt_valid) begin
                rd_address    <= sel_addr;
                rd_word_count <= sel_count;
                grant_b       <= gnt_pick_b;
                last_b        <= gnt_pick_b;
                word_cnt      <= '0;
                rd_start      <= (sel_count != '0);
            end

            if (state == ISSUE && rd_done)
                rd_start <= 1'b0;

            if (fwd) begin
                word_cnt <= word_cnt + ADDR_W'(1);
                if (grant_b == PORT_B) begin
                    b_strobe <= 1'b1;
                    b_data   <= rd_data;
                end else begin
                    a_strobe <= 1'b1;
                    a_data   <= rd_data;
                end
            end
        end
    end

    // A zero count is always an error even though the counter trivially matches it.
    always_comb begin
        busy      = (state != IDLE);
        ack_cycle = (state == ACK);
        xfer_err  = (rd_word_count == '0) || (word_cnt != rd_word_count);
        a_ack     = ack_cycle && (grant_b == PORT_A);
        b_ack     = ack_cycle && (grant_b == PORT_B);
        a_err     = a_ack && xfer_err;
        b_err     = b_ack && xfer_err;
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a behavioural flash read engine.
module tb_flash_read_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        a_req, b_req;
    logic [23:0] a_addr, a_count, b_addr, b_count;
    logic        a_strobe, a_ack, a_err, b_strobe, b_ack, b_err;
    logic [31:0] a_data, b_data;
    logic        rd_start, rd_strobe, rd_done, busy, grant_b;
    logic [23:0] rd_address, rd_word_count;
    logic [31:0] rd_data;

    int n_chk = 0;
    int n_pass = 0;

    int eng_words = 0;
    int eng_gap = 0;
    int eng_coincide = 0;
    int a_more = 0;
    int b_more = 0;

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    int          order_q[$];
    int          a_acks = 0;
    int          b_acks = 0;
    logic        a_err_last = 1'b0;
    logic        b_err_last = 1'b0;
    logic        start_seen = 1'b0;

    always #5 clk = ~clk;

    flash_read_arbiter #(.ADDR_W(24), .RESET_PRIO_A(1'b1)) dut (
        .clk(clk), .n_reset(n_reset),
        .a_req(a_req), .a_addr(a_addr), .a_count(a_count),
        .a_strobe(a_strobe), .a_data(a_data), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_addr(b_addr), .b_count(b_count),
        .b_strobe(b_strobe), .b_data(b_data), .b_ack(b_ack), .b_err(b_err),
        .rd_start(rd_start), .rd_address(rd_address), .rd_word_count(rd_word_count),
        .rd_strobe(rd_strobe), .rd_data(rd_data), .rd_done(rd_done),
        .busy(busy), .grant_b(grant_b)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'h11111111 * (i + 1);
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxxxxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Engine model: eng_gap idle cycles before each word, then done held until rd_start falls.
    initial begin
        rd_strobe = 1'b0;
        rd_done   = 1'b0;
        rd_data   = '0;
        forever begin
            do begin @(posedge clk); #1; end while (!rd_start);
            for (int i = 0; i < eng_words; i++) begin
                repeat (eng_gap) begin @(posedge clk); #1; end
                if (!rd_start) break;
                rd_strobe = 1'b1;
                rd_data   = pat(i);
                if (eng_coincide != 0 && i == eng_words - 1) rd_done = 1'b1;
                @(posedge clk); #1;
                rd_strobe = 1'b0;
                rd_data   = '0;
            end
            if (rd_start) rd_done = 1'b1;
            while (rd_start) begin @(posedge clk); #1; end
            rd_done = 1'b0;
        end
    end

    // Requesters drop req on the edge ending their ack, optionally re-requesting a cycle later.
    initial forever begin
        @(negedge clk);
        if (a_ack) begin
            @(posedge clk); #1; a_req = 1'b0;
            if (a_more > 0) begin a_more--; @(posedge clk); #1; a_req = 1'b1; end
        end
    end

    initial forever begin
        @(negedge clk);
        if (b_ack) begin
            @(posedge clk); #1; b_req = 1'b0;
            if (b_more > 0) begin b_more--; @(posedge clk); #1; b_req = 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (a_strobe) a_q.push_back(a_data);
        if (b_strobe) b_q.push_back(b_data);
        if (a_ack) begin a_acks++; a_err_last = a_err; order_q.push_back(0); end
        if (b_ack) begin b_acks++; b_err_last = b_err; order_q.push_back(1); end
        if (rd_start) start_seen = 1'b1;
    end

    task automatic clear_log();
        a_q.delete(); b_q.delete(); order_q.delete();
        a_acks = 0; b_acks = 0; start_seen = 1'b0;
        a_err_last = 1'b0; b_err_last = 1'b0;
    endtask

    task automatic wait_acks(input string tag, input int target);
        int cyc = 0;
        while ((a_acks + b_acks) < target && cyc < 500) begin @(negedge clk); cyc++; end
        chk(tag, 32'((a_acks + b_acks) >= target), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        n_reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        n_reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        a_addr = '0; a_count = '0; b_addr = '0; b_count = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", {23'd0, rd_start, busy, grant_b, a_strobe, b_strobe, a_ack, b_ack, a_err, b_err}, 32'd0);
        chk("rst_addr", {8'd0, rd_address}, 32'd0);
        chk("rst_data", a_data | b_data, 32'd0);
        n_reset = 1'b1;

        // Single A transfer of three words.
        clear_log();
        a_addr = 24'h000100; a_count = 24'd3; eng_words = 3;
        @(posedge clk); #1 a_req = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t1_start", {31'd0, rd_start}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_acks("t1_done", 1);
        chk("t1_nwords", a_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) chk("t1_word", qget(a_q, i), pat(i));
        chk("t1_acks", a_acks, 32'd1);
        chk("t1_err", {31'd0, a_err_last}, 32'd0);
        chk("t1_b_quiet", b_q.size() + b_acks, 32'd0);
        chk("t1_addr", {8'd0, rd_address}, 32'h000100);
        chk("t1_cnt", {8'd0, rd_word_count}, 32'd3);

        // Simultaneous requests after reset: A first, then alternation.
        do_reset();
        clear_log();
        a_addr = 24'h000010; a_count = 24'd2; b_addr = 24'h000020; b_count = 24'd2; eng_words = 2;
        a_more = 1; b_more = 0;
        a_req = 1'b1; b_req = 1'b1;
        wait_acks("t2_done", 3);
        chk("t2_ord0", order_q.size() > 0 ? order_q[0] : -1, 32'd0);
        chk("t2_ord1", order_q.size() > 1 ? order_q[1] : -1, 32'd1);
        chk("t2_ord2", order_q.size() > 2 ? order_q[2] : -1, 32'd0);
        chk("t2_bword", qget(b_q, 1), pat(1));
        // A was served last, so a fresh tie goes to B.
        clear_log();
        a_req = 1'b1; b_req = 1'b1;
        wait_acks("t2b_done", 2);
        chk("t2b_ord0", order_q.size() > 0 ? order_q[0] : -1, 32'd1);
        chk("t2b_ord1", order_q.size() > 1 ? order_q[1] : -1, 32'd0);
        chk("t2b_words", a_q.size() + b_q.size(), 32'd4);

        // Zero-length B request: immediate error ack, engine untouched.
        clear_log();
        b_count = 24'd0;
        @(posedge clk); #1 b_req = 1'b1;
        cyc = 0;
        while (!b_ack && cyc < 10) begin @(negedge clk); cyc++; end
        chk("t3_lat", {31'd0, (cyc <= 3)}, 32'd1);
        chk("t3_err", {31'd0, b_err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_acks", b_acks, 32'd1);
        chk("t3_nostart", {31'd0, start_seen}, 32'd0);
        chk("t3_grant", {31'd0, grant_b}, 32'd1);

        // Engine delivers two of three words.
        clear_log();
        a_count = 24'd3; eng_words = 2;
        @(posedge clk); #1 a_req = 1'b1;
        wait_acks("t4_done", 1);
        chk("t4_nwords", a_q.size(), 32'd2);
        chk("t4_err", {31'd0, a_err_last}, 32'd1);

        // Last strobe coincides with done.
        clear_log();
        a_count = 24'd2; eng_words = 2; eng_coincide = 1;
        @(posedge clk); #1 a_req = 1'b1;
        wait_acks("t5_done", 1);
        chk("t5_nwords", a_q.size(), 32'd2);
        chk("t5_last", qget(a_q, 1), pat(1));
        chk("t5_err", {31'd0, a_err_last}, 32'd0);
        eng_coincide = 0;

        // Reset mid-transfer, then a clean single-word transfer.
        clear_log();
        a_count = 24'd5; eng_words = 5; eng_gap = 2;
        @(posedge clk); #1 a_req = 1'b1;
        cyc = 0;
        while (a_q.size() < 2 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t6_two", a_q.size(), 32'd2);
        #1 n_reset = 1'b0; a_req = 1'b0;
        #1;
        chk("t6_rst_ctl", {23'd0, rd_start, busy, grant_b, a_strobe, b_strobe, a_ack, b_ack, a_err, b_err}, 32'd0);
        chk("t6_rst_addr", {8'd0, rd_word_count}, 32'd0);
        chk("t6_rst_data", a_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        eng_gap = 0;
        clear_log();
        a_count = 24'd1; eng_words = 1;
        @(posedge clk); #1 a_req = 1'b1;
        wait_acks("t6_done", 1);
        chk("t6_nwords", a_q.size(), 32'd1);
        chk("t6_word", qget(a_q, 0), pat(0));
        chk("t6_err", {31'd0, a_err_last}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
